mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Single-port memory arbiter and MMIO decoder for the RV32I core. It shares one word-wide synchronous memory between the instruction-fetch requester and the load/store requester, one grant per cycle. It performs byte-lane extraction and sign extension for loads and byte-enable generation for stores. It also intercepts the console and exit MMIO addresses, so the core's decoder no longer accesses `memory[]` directly.

## Interface
- `MEMORY_LEN`, 1024, memory depth in 32-bit words (power of two)
- `MEMORY_BITS`, `$clog2(MEMORY_LEN)`, word-index width
- `STARVE_LIMIT`, 4, consecutive denied fetch cycles before fetch is forced to win (1..15)
- `clk` in 1: the only clock; all logic on posedge
- `rst` in 1: synchronous, active-high reset
- `if_req` in 1, `if_addr` in 32: fetch request and byte address
- `if_gnt` out 1: combinational fetch grant
- `if_rvalid` out 1, `if_rdata` out 32: fetch response
- `d_req` in 1, `d_we` in 1, `d_size` in 2 (0 byte, 1 half, 2 word), `d_unsigned` in 1, `d_addr` in 32, `d_wdata` in 32: data request
- `d_gnt` out 1: combinational data grant
- `d_rvalid` out 1, `d_rdata` out 32: load response
- `d_err` out 1: misaligned-access pulse
- `mem_en` out 1, `mem_we` out 1, `mem_be` out 4, `mem_addr` out MEMORY_BITS, `mem_wdata` out 32: memory command
- `mem_rdata` in 32: memory read data, valid the cycle after `mem_en` with `!mem_we`
- `con_valid` out 1, `con_char` out 8: console write strobe
- `exit_valid` out 1, `exit_code` out 32: program-exit strobe

## Operation
- States: RUN and HALT. Reset enters RUN. Entry to HALT is defined under Configuration. HALT is left only by `rst`; while in HALT, both `if_gnt` and `d_gnt` are 0.
- Arbitration in RUN:
  - Only one of `if_gnt` or `d_gnt` is high in a cycle.
  - Data has priority, except when `starve_cnt == STARVE_LIMIT` with `if_req` high; then fetch wins.
  - `starve_cnt` increments in each cycle where `if_req && !if_gnt`, and saturates at `STARVE_LIMIT`.
  - `starve_cnt` clears on `if_gnt` or when `!if_req`.
- Handshake: a requester holds its req and its request fields stable until it sees gnt high. A transfer occurs on the cycle req and gnt are both high.
- Address: word index is `addr[MEMORY_BITS+1:2]`. Upper bits are ignored, so addresses alias and wrap around.
- Fetch transfer: `mem_en=1`, `mem_we=0`; `if_addr[1:0]` is ignored.
- Misalignment: half with `addr[0]=1`, or word with `addr[1:0]!=0`.
  - The request is granted, but no memory command is issued.
  - `d_err=1` the next cycle; `d_rvalid` stays 0.
  - `d_size=3` is treated as misaligned.
- Store transfer: `mem_we=1`.
  - `mem_be`: byte gives `4'b0001<<addr[1:0]`; half gives `4'b0011<<addr[1:0]`; word gives `4'b1111`.
  - `mem_wdata`: byte is replicated ×4, half is replicated ×2, word is passed through.
- Load transfer: lane offset, size and signedness are registered at grant. The next cycle, `d_rdata` is `mem_rdata>>(8*offset)`, truncated to the size, then sign-extended (if `d_unsigned=0`) or zero-extended.
- Idle: all `mem_*` outputs are 0 when there is no transfer.

## Timing
- Reset values: every output is 0, `starve_cnt=0`, state RUN, and the response pipeline is cleared. The grants stay 0 during the `rst` cycle.
- Read latency: a grant in cycle N gives `rvalid` in cycle N+1, together with the data. There is no backpressure: the requester must accept the response.
- A new grant is allowed in cycle N+1, so back-to-back transfers achieve throughput of 1 per cycle.
- Stores complete at the grant edge. A load of the same word granted in the next cycle returns the new data, because the memory is write-before-read across cycles.
- Reset asserted in the cycle after a grant: that response is dropped (`rvalid=0`).
- MMIO strobes, `d_err` and `exit_valid` are single-cycle pulses in cycle N+1.

## Configuration
- `MMIO_EN` defined:
  - Store to `0xFFFF0000`: no memory write; `con_valid=1` and `con_char=d_wdata[7:0]` in N+1.
  - Store to `0xABCD0000`: no memory write; `exit_valid=1` and `exit_code=d_wdata` in N+1; the block enters HALT at the same edge.
  - Loads from either address return 0 with `d_rvalid=1` in N+1, and issue no memory command.
  - The MMIO address check precedes the misalignment check.
- `MMIO_EN` undefined: both addresses are ordinary (aliased) memory. `con_*` and `exit_*` are tied to 0, and HALT is unreachable.

## Test plan
- Reset: hold `rst` with both reqs high → all outputs 0. First cycle after reset: `d_gnt=1`, `if_gnt=0`.
- Starvation: `d_req` and `if_req` both held high with `STARVE_LIMIT=4` → data granted 4 cycles, then fetch granted in the 5th; the pattern repeats.
- Byte load: memory word 0x000000F0 holds 0x80FF7F01; LB at 0x3C2 → `d_rdata=0xFFFFFFFF`; LBU at 0x3C3 → `d_rdata=0x00000080`; LH at 0x3C2 → `d_rdata=0xFFFF80FF`; LHU at 0x3C2 → `d_rdata=0x000080FF`.
- Stores: SB 0xAA at 0x101 → `mem_be=0010`, `mem_wdata=0xAAAAAAAA`. SH at 0x103 → `d_err` pulse, `mem_en=0`.
- Wrap: LW from `0x00001010` with `MEMORY_LEN=1024` → `mem_addr=4`.
- MMIO (`MMIO_EN`): SB 0x41 to `0xFFFF0000` → `con_valid`, `con_char=0x41`, no `mem_we`. SW 7 to `0xABCD0000` → `exit_code=7`; afterwards `if_gnt=0` forever until `rst`.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for the fetch and load/store ports, with load lane extraction and
// store byte enables. Define MMIO_EN to decode the console (0xFFFF0000) and exit (0xABCD0000) MMIO.
module mem_port_arbiter #(
  parameter int unsigned MEMORY_LEN   = 1024,
  parameter int unsigned MEMORY_BITS  = $clog2(MEMORY_LEN),
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_req,
  input  logic [31:0]            if_addr,
  output logic                   if_gnt,
  output logic                   if_rvalid,
  output logic [31:0]            if_rdata,
  input  logic                   d_req,
  input  logic                   d_we,
  input  logic [1:0]             d_size,
  input  logic                   d_unsigned,
  input  logic [31:0]            d_addr,
  input  logic [31:0]            d_wdata,
  output logic                   d_gnt,
  output logic                   d_rvalid,
  output logic [31:0]            d_rdata,
  output logic                   d_err,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [3:0]             mem_be,
  output logic [MEMORY_BITS-1:0] mem_addr,
  output logic [31:0]            mem_wdata,
  input  logic [31:0]            mem_rdata,
  output logic                   con_valid,
  output logic [7:0]             con_char,
  output logic                   exit_valid,
  output logic [31:0]            exit_code
);

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e     state_q, state_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       if_rvalid_q, if_rvalid_d;
  logic       d_rvalid_q, d_rvalid_d;
  logic       d_err_q, d_err_d;
  logic       ld_zero_q, ld_zero_d;
  logic       ld_uns_q, ld_uns_d;
  logic [1:0] ld_off_q, ld_off_d;
  logic [1:0] ld_size_q, ld_size_d;

  logic        run, fetch_wins, mmio_con, mmio_exit, mmio_hit, misaligned, d_mem;
  logic [31:0] ld_shift;
  logic        unused_addr;

  assign unused_addr = ^{if_addr[31:MEMORY_BITS+2], if_addr[1:0], d_addr[31:MEMORY_BITS+2]};

  // Grants are held low during the reset cycle and forever once halted.
  assign run        = (state_q == StRun) && !rst;
  assign fetch_wins = if_req && (starve_cnt_q == 4'(STARVE_LIMIT));
  assign d_gnt      = run && d_req && !fetch_wins;
  assign if_gnt     = run && if_req && !d_gnt;

`ifdef MMIO_EN
  assign mmio_con  = (d_addr == 32'hFFFF_0000);
  assign mmio_exit = (d_addr == 32'hABCD_0000);
`else
  assign mmio_con  = 1'b0;
  assign mmio_exit = 1'b0;
`endif
  assign mmio_hit = mmio_con || mmio_exit;

  always_comb begin
    misaligned = 1'b0;
    case (d_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = d_addr[0];
      2'd2:    misaligned = |d_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  assign d_mem = d_gnt && !mmio_hit && !misaligned;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    if (if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = if_addr[MEMORY_BITS+1:2];
    end else if (d_mem) begin
      mem_en   = 1'b1;
      mem_we   = d_we;
      mem_addr = d_addr[MEMORY_BITS+1:2];
      if (d_we) begin
        unique case (d_size)
          2'd0: begin
            mem_be    = 4'b0001 << d_addr[1:0];
            mem_wdata = {4{d_wdata[7:0]}};
          end
          2'd1: begin
            mem_be    = 4'b0011 << d_addr[1:0];
            mem_wdata = {2{d_wdata[15:0]}};
          end
          default: begin
            mem_be    = 4'b1111;
            mem_wdata = d_wdata;
          end
        endcase
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    if (!if_req || if_gnt) begin
      starve_cnt_d = 4'd0;
    end else if (starve_cnt_q < 4'(STARVE_LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
    if (d_gnt && d_we && mmio_exit) state_d = StHalt;
    if_rvalid_d = if_gnt;
    // MMIO loads answer zero without touching memory.
    d_rvalid_d  = d_gnt && !d_we && (mmio_hit || !misaligned);
    d_err_d     = d_gnt && !mmio_hit && misaligned;
    ld_zero_d   = mmio_hit;
    ld_off_d    = d_addr[1:0];
    ld_size_d   = d_size;
    ld_uns_d    = d_unsigned;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StRun;
      starve_cnt_q <= 4'd0;
      if_rvalid_q  <= 1'b0;
      d_rvalid_q   <= 1'b0;
      d_err_q      <= 1'b0;
      ld_zero_q    <= 1'b0;
      ld_uns_q     <= 1'b0;
      ld_off_q     <= 2'd0;
      ld_size_q    <= 2'd0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      if_rvalid_q  <= if_rvalid_d;
      d_rvalid_q   <= d_rvalid_d;
      d_err_q      <= d_err_d;
      ld_zero_q    <= ld_zero_d;
      ld_uns_q     <= ld_uns_d;
      ld_off_q     <= ld_off_d;
      ld_size_q    <= ld_size_d;
    end
  end

  // Responses in flight are dropped while reset is asserted.
  assign if_rvalid = if_rvalid_q && !rst;
  assign if_rdata  = if_rvalid ? mem_rdata : 32'h0;
  assign d_rvalid  = d_rvalid_q && !rst;
  assign d_err     = d_err_q && !rst;
  assign ld_shift  = mem_rdata >> {ld_off_q, 3'b000};

  always_comb begin
    d_rdata = 32'h0;
    if (d_rvalid && !ld_zero_q) begin
      unique case (ld_size_q)
        2'd0:    d_rdata = {{24{!ld_uns_q && ld_shift[7]}}, ld_shift[7:0]};
        2'd1:    d_rdata = {{16{!ld_uns_q && ld_shift[15]}}, ld_shift[15:0]};
        default: d_rdata = ld_shift;
      endcase
    end
  end

`ifdef MMIO_EN
  logic        con_valid_q, con_valid_d, exit_valid_q, exit_valid_d;
  logic [7:0]  con_char_q, con_char_d;
  logic [31:0] exit_code_q, exit_code_d;

  always_comb begin
    con_valid_d  = d_gnt && d_we && mmio_con;
    con_char_d   = con_valid_d ? d_wdata[7:0] : 8'h0;
    exit_valid_d = d_gnt && d_we && mmio_exit;
    exit_code_d  = exit_valid_d ? d_wdata : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      con_valid_q  <= 1'b0;
      con_char_q   <= 8'h0;
      exit_valid_q <= 1'b0;
      exit_code_q  <= 32'h0;
    end else begin
      con_valid_q  <= con_valid_d;
      con_char_q   <= con_char_d;
      exit_valid_q <= exit_valid_d;
      exit_code_q  <= exit_code_d;
    end
  end

  assign con_valid  = con_valid_q && !rst;
  assign con_char   = con_valid ? con_char_q : 8'h0;
  assign exit_valid = exit_valid_q && !rst;
  assign exit_code  = exit_valid ? exit_code_q : 32'h0;
`else
  assign con_valid  = 1'b0;
  assign con_char   = 8'h0;
  assign exit_valid = 1'b0;
  assign exit_code  = 32'h0;
`endif

endmodule
